// File: rtl/store_checker.sv
// store_checker: compares core data-memory stores against a programmed table of expected
// address/data pairs and reports pass/fail/timeout. Define STORE_CHECKER_LAST_EN to build last-store capture.
module store_checker #(
  parameter int XLEN           = 32,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 10000,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            ordered,
  input  logic [CW-1:0]   exp_count,
  input  logic            exp_we,
  input  logic [IW-1:0]   exp_idx,
  input  logic [XLEN-1:0] exp_addr,
  input  logic [XLEN-1:0] exp_data,
  input  logic            mem_write,
  input  logic [XLEN-1:0] data_adr,
  input  logic [XLEN-1:0] write_data,
  output logic            busy,
  output logic            pass,
  output logic            fail,
  output logic [1:0]      fail_code,
  output logic [CW-1:0]   match_idx,
  output logic [TW-1:0]   cycle_cnt,
  output logic [XLEN-1:0] last_addr,
  output logic [XLEN-1:0] last_data
);

  // state | meaning
  // IDLE  | table programmable, waiting for start
  // RUN   | sampling stores, counting cycles toward timeout
  // PASS  | all expected stores seen; table programmable, start re-arms
  // FAIL  | mismatch or timeout; table programmable, start re-arms
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

  state_t          state;
  logic            ordered_q;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] tbl_addr [DEPTH];
  logic [XLEN-1:0] tbl_data [DEPTH];

  logic            hit;
  logic            timeout;
  logic [CW-1:0]   match_nxt;
  logic [TW-1:0]   cnt_inc;

  always_comb begin
    hit       = (data_adr == tbl_addr[match_idx[IW-1:0]]) &&
                (write_data == tbl_data[match_idx[IW-1:0]]);
    timeout   = (cycle_cnt == TMO_LAST);
    match_nxt = match_idx + CW'(1);
    cnt_inc   = (cycle_cnt == TMO_MAX) ? cycle_cnt : cycle_cnt + TW'(1);
  end

  // The table is frozen while a run is in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_addr[i] <= '0;
        tbl_data[i] <= '0;
      end
    end else if (exp_we && state != S_RUN) begin
      tbl_addr[exp_idx] <= exp_addr;
      tbl_data[exp_idx] <= exp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ordered_q <= 1'b0;
      count_q   <= '0;
      busy      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 2'd0;
      match_idx <= '0;
      cycle_cnt <= '0;
    end else begin
      case (state)
        S_RUN: begin
          // cycle_cnt only advances on edges that stay in RUN, so it holds the
          // count seen on the deciding edge.
          if (count_q == '0) begin
            state <= S_PASS;
            busy  <= 1'b0;
            pass  <= 1'b1;
          end else if (mem_write && hit) begin
            match_idx <= match_nxt;
            if (match_nxt == count_q) begin
              state <= S_PASS;
              busy  <= 1'b0;
              pass  <= 1'b1;
            end else if (timeout) begin
              state     <= S_FAIL;
              busy      <= 1'b0;
              fail      <= 1'b1;
              fail_code <= 2'd2;
            end else begin
              cycle_cnt <= cnt_inc;
            end
          end else if (mem_write && ordered_q) begin
            state     <= S_FAIL;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_code <= 2'd1;
          end else if (timeout) begin
            state     <= S_FAIL;
            busy      <= 1'b0;
            fail      <= 1'b1;
            fail_code <= 2'd2;
          end else begin
            cycle_cnt <= cnt_inc;
          end
        end
        default: begin
          if (start) begin
            state     <= S_RUN;
            busy      <= 1'b1;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= 2'd0;
            match_idx <= '0;
            cycle_cnt <= '0;
            ordered_q <= ordered;
            count_q   <= (exp_count > DEPTH_C) ? DEPTH_C : exp_count;
          end
        end
      endcase
    end
  end

`ifdef STORE_CHECKER_LAST_EN
  logic [XLEN-1:0] last_addr_q;
  logic [XLEN-1:0] last_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_addr_q <= '0;
      last_data_q <= '0;
    end else if (state != S_RUN && start) begin
      last_addr_q <= '0;
      last_data_q <= '0;
    end else if (state == S_RUN && mem_write && count_q != '0) begin
      last_addr_q <= data_adr;
      last_data_q <= write_data;
    end
  end

  assign last_addr = last_addr_q;
  assign last_data = last_data_q;
`else
  assign last_addr = '0;
  assign last_data = '0;
`endif

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker: expected run outcomes are queued when a run is armed
// and compared when the checker leaves RUN.
module tb_store_checker;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 50;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int IW    = $clog2(DEPTH);
  localparam int TW    = $clog2(TMO + 1);

  logic            clk = 1'b0;
  logic            reset, start, ordered, exp_we, mem_write;
  logic [CW-1:0]   exp_count;
  logic [IW-1:0]   exp_idx;
  logic [XLEN-1:0] exp_addr, exp_data, data_adr, write_data;
  logic            busy, pass, fail;
  logic [1:0]      fail_code;
  logic [CW-1:0]   match_idx;
  logic [TW-1:0]   cycle_cnt;
  logic [XLEN-1:0] last_addr, last_data;

  store_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .ordered(ordered), .exp_count(exp_count),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
    .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code), .match_idx(match_idx),
    .cycle_cnt(cycle_cnt), .last_addr(last_addr), .last_data(last_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            p;
    logic            f;
    logic [1:0]      code;
    logic [CW-1:0]   mi;
    logic [TW-1:0]   cc;
    logic [XLEN-1:0] la;
    logic [XLEN-1:0] ld;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic p, input logic f, input logic [1:0] code, input int mi,
                      input int cc, input logic [XLEN-1:0] la, input logic [XLEN-1:0] ld);
    exp_t e;
    e.p = p; e.f = f; e.code = code; e.mi = CW'(mi); e.cc = TW'(cc);
`ifdef STORE_CHECKER_LAST_EN
    e.la = la; e.ld = ld;
`else
    e.la = '0; e.ld = '0;
`endif
    sb.push_back(e);
  endtask

  task automatic write_entry(input int idx, input int a, input int d);
    exp_we = 1'b1; exp_idx = IW'(idx); exp_addr = XLEN'(a); exp_data = XLEN'(d);
    tick();
    exp_we = 1'b0;
  endtask

  task automatic start_run(input logic ord, input int cnt);
    ordered = ord; exp_count = CW'(cnt); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input int a, input int d);
    mem_write = 1'b1; data_adr = XLEN'(a); write_data = XLEN'(d);
    tick();
    mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_busy"}, 64'(busy), 64'd0);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_sb: observed empty scoreboard, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_pass"},  64'(pass),      64'(e.p));
      check({tag, "_fail"},  64'(fail),      64'(e.f));
      check({tag, "_code"},  64'(fail_code), 64'(e.code));
      check({tag, "_midx"},  64'(match_idx), 64'(e.mi));
      check({tag, "_cycle"}, 64'(cycle_cnt), 64'(e.cc));
      check({tag, "_laddr"}, 64'(last_addr), 64'(e.la));
      check({tag, "_ldata"}, 64'(last_data), 64'(e.ld));
    end
    check({tag, "_excl"}, 64'(pass & fail), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},  64'(busy),      64'd0);
    check({tag, "_pass"},  64'(pass),      64'd0);
    check({tag, "_fail"},  64'(fail),      64'd0);
    check({tag, "_code"},  64'(fail_code), 64'd0);
    check({tag, "_midx"},  64'(match_idx), 64'd0);
    check({tag, "_cycle"}, 64'(cycle_cnt), 64'd0);
    check({tag, "_laddr"}, 64'(last_addr), 64'd0);
    check({tag, "_ldata"}, 64'(last_data), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ordered = 1'b0; exp_count = '0; exp_we = 1'b0;
    exp_idx = '0; exp_addr = '0; exp_data = '0; mem_write = 1'b0; data_adr = '0; write_data = '0;
    tick(); tick();
    reset = 1'b0;
    check_reset_state("rst");

    // single entry, store three cycles after start
    write_entry(0, 216, 4140);
    push(1, 0, 2'd0, 1, 2, 216, 4140);
    start_run(1'b1, 1);
    check("t1_busy_k1", 64'(busy), 64'd1);
    idle(2);
    store(216, 4140);
    check("t1_now", 64'({busy, pass}), 64'b01);
    wait_done("t1");

    // strict-order mismatch
    write_entry(0, 100, 25);
    write_entry(1, 104, 7);
    push(0, 1, 2'd1, 1, 1, 104, 8);
    start_run(1'b1, 2);
    store(100, 25);
    store(104, 8);
    wait_done("t2");

    // subsequence with unrelated stores interleaved
    push(1, 0, 2'd0, 2, 3, 104, 7);
    start_run(1'b0, 2);
    store(96, 1);
    store(100, 25);
    store(200, 3);
    check("t3_busy_mid", 64'(busy), 64'd1);
    store(104, 7);
    check("t3_now", 64'({busy, pass}), 64'b01);
    wait_done("t3");

    // timeout with no stores
    push(0, 1, 2'd2, 0, 49, 0, 0);
    start_run(1'b1, 1);
    idle(49);
    check("t4_busy_49", 64'(busy), 64'd1);
    check("t4_cnt_49", 64'(cycle_cnt), 64'd49);
    tick();
    wait_done("t4");

    // final match on the timeout edge wins
    push(1, 0, 2'd0, 1, 49, 100, 25);
    start_run(1'b1, 1);
    idle(49);
    store(100, 25);
    wait_done("t4b");

    // ordered mismatch on the timeout edge reports mismatch
    push(0, 1, 2'd1, 0, 49, 100, 26);
    start_run(1'b1, 1);
    idle(49);
    store(100, 26);
    wait_done("t4c");

    // empty table passes on the first RUN cycle
    push(1, 0, 2'd0, 0, 0, 0, 0);
    start_run(1'b1, 0);
    check("t5_busy_k1", 64'(busy), 64'd1);
    tick();
    wait_done("t5");

    // restart clears pass; start and exp_we inside RUN are ignored
    push(1, 0, 2'd0, 2, 6, 104, 7);
    start_run(1'b1, 2);
    check("t5b_cleared", 64'({busy, pass, fail}), 64'b100);
    idle(3);
    start_run(1'b0, 0);
    check("t5b_cnt", 64'(cycle_cnt), 64'd4);
    check("t5b_busy", 64'(busy), 64'd1);
    write_entry(1, 104, 99);
    store(100, 25);
    store(104, 7);
    wait_done("t5b");

    // count above DEPTH clamps to DEPTH
    write_entry(0, 16, 1);
    write_entry(1, 20, 2);
    write_entry(2, 24, 3);
    write_entry(3, 28, 4);
    push(1, 0, 2'd0, 4, 3, 28, 4);
    start_run(1'b1, 7);
    store(16, 1);
    store(20, 2);
    store(24, 3);
    store(28, 4);
    wait_done("t7");

    // reset mid-RUN after one match
    start_run(1'b1, 2);
    store(16, 1);
    check("t6_midx_pre", 64'(match_idx), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("t6_rst");

    // table was cleared by reset: entry 0 now holds 0/0
    push(1, 0, 2'd0, 1, 0, 0, 0);
    start_run(1'b1, 1);
    store(0, 0);
    wait_done("t6_clr");

    // table write coincident with start is used from the first sample
    push(1, 0, 2'd0, 1, 0, 8, 9);
    exp_we = 1'b1; exp_idx = '0; exp_addr = 32'd8; exp_data = 32'd9;
    start_run(1'b1, 1);
    exp_we = 1'b0;
    store(8, 9);
    wait_done("t6_we");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_checker.md
# store_checker

Synthesizable self-check block that watches the core's data-memory write port (`mem_write`, `data_adr`, `write_data`) and compares stores against a programmed list of up to DEPTH expected address/data pairs. It is the parametrised successor to the single "store X to address Y" check in our single-cycle CPU benches. It reports pass, fail, or timeout through registered status outputs, so the same check runs in simulation and on FPGA. It sits beside `top`, tapping the same three signals the bench monitors.

## Interface

Parameters:
- XLEN, 32, width of address and data
- DEPTH, 4, maximum number of expected stores
- TIMEOUT_CYCLES, 10000, number of RUN cycles allowed before a timeout failure

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that arms a check run
- ordered  in  1  mode select, sampled at start: 1 = strict, 0 = subsequence
- exp_count  in  $clog2(DEPTH+1)  number of valid table entries, sampled at start
- exp_we  in  1  table write enable
- exp_idx  in  $clog2(DEPTH)  table write index
- exp_addr  in  XLEN  expected address to write
- exp_data  in  XLEN  expected data to write
- mem_write  in  1  core store strobe
- data_adr  in  XLEN  core store address
- write_data  in  XLEN  core store data
- busy  out  1  high in RUN
- pass  out  1  sticky pass flag
- fail  out  1  sticky fail flag
- fail_code  out  2  reason for failure: 0 none, 1 mismatch, 2 timeout
- match_idx  out  $clog2(DEPTH+1)  number of entries matched so far
- cycle_cnt  out  $clog2(TIMEOUT_CYCLES+1)  RUN cycle counter
- last_addr  out  XLEN  address of the last sampled store (see Configuration)
- last_data  out  XLEN  data of the last sampled store (see Configuration)

## Operation

FSM states: IDLE, RUN, PASS, FAIL. Reset forces IDLE.

- IDLE, PASS, FAIL:
  - `exp_we` writes `exp_addr`/`exp_data` into entry `exp_idx`.
  - `start` goes to RUN and latches `ordered` and `exp_count`.
  - `start` clears `match_idx`, `cycle_cnt`, `pass`, `fail`, and `fail_code`.
- RUN:
  - `exp_we` is ignored.
  - `start` is ignored.
  - `cycle_cnt` increments every cycle and saturates at TIMEOUT_CYCLES.
- Store sampling, each rising edge in RUN with `mem_write`=1:
  - Compare `{data_adr, write_data}` against entry `match_idx`.
  - Match: increment `match_idx`. If the new value equals the latched count, go to PASS.
  - Mismatch, `ordered`=1: go to FAIL with `fail_code`=1.
  - Mismatch, `ordered`=0: ignore the store.
- Timeout: when `cycle_cnt` reaches TIMEOUT_CYCLES-1 in RUN, go to FAIL with `fail_code`=2.
- Latched `exp_count`=0: RUN goes to PASS on the first RUN cycle without sampling.
- Latched `exp_count` greater than DEPTH is clamped to DEPTH.
- Entries are compared with full-width equality; there are no don't-care bits.

## Timing

- Reset values:
  - state IDLE
  - `busy`, `pass`, `fail` = 0
  - `fail_code`, `match_idx`, `cycle_cnt` = 0
  - `last_addr`, `last_data` = 0
  - all table entries = 0
- `start` sampled high at edge k: `busy`=1 from k+1 through the edge that leaves RUN. The first store that can be sampled is at edge k+1.
- Final match sampled at edge m: `pass`=1 and `busy`=0 visible after edge m. Latency is 0 cycles after the sampling edge; all outputs are registered.
- `pass` and `fail` hold until the next `start` or `reset`, and are never high together.
- Final match and timeout on the same edge: PASS wins.
- Mismatch (ordered) and timeout on the same edge: FAIL with `fail_code`=1.
- `reset` mid-RUN: IDLE on the next edge. All counters and flags clear, and the table clears.
- `exp_we` together with `start` in IDLE: the write takes effect, and the run uses the updated table from its first sample.

## Configuration

- `STORE_CHECKER_LAST_EN` defined:
  - Every sampled store in RUN captures `data_adr`/`write_data` into `last_addr`/`last_data`.
  - Captures also occur on the mismatching or final store.
  - The registers hold across PASS/FAIL and clear on `reset` or `start`.
- Not defined: `last_addr`/`last_data` are tied to 0 and no capture registers are built.

## Test plan

- Single entry {216, 4140}, `exp_count`=1, `ordered`=1 → one store of 216/4140 three cycles after `start` → `pass`=1 the edge it is sampled, `match_idx`=1, `fail_code`=0.
- Strict-order mismatch: table {100,25},{104,7}, `ordered`=1 → store 100/25 then 104/8 → `fail`=1, `fail_code`=1, `match_idx`=1 (with the macro defined, `last_data`=8).
- Subsequence: same table, `ordered`=0 → stores 96/1, 100/25, 200/3, 104/7 → `pass`=1 after the 4th store, `match_idx`=2.
- Timeout: TIMEOUT_CYCLES=50, `exp_count`=1, no stores → `fail`=1, `fail_code`=2 with `cycle_cnt`=49 at the failing edge. A matching store on that same edge → `pass` instead.
- `exp_count`=0 → `pass`=1 one cycle after `start`. A second `start` clears `pass` and re-arms; `start` pulses during RUN do not reset `cycle_cnt`.
- Assert `reset` mid-RUN after one match → all outputs return to reset values. A re-programmed table plus `start` runs cleanly.
